// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execute ALU with 1-cycle single ops and an iterative
// shift-add multiplier (MUL low half / MULHU high half) taking WIDTH cycles.
module alu_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SLL   = 4'd1;
    localparam logic [3:0] OP_SLT   = 4'd2;
    localparam logic [3:0] OP_SLTU  = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_SUB   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Flag vector {zero, negative, carry, overflow} derived from the final result.
    function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] r,
                                              input logic c,
                                              input logic v);
        return {(r == {WIDTH{1'b0}}), r[WIDTH-1], c, v};
    endfunction

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_res;
    logic [3:0]             r_flags;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;
    logic [SHW-1:0]         r_count;
    logic                   r_is_hi;

    logic                   w_accept;
    logic                   w_is_mul;
    logic                   w_load;
    logic [WIDTH-1:0]       w_res_d;
    logic [3:0]             w_flags_d;
    logic [WIDTH-1:0]       w_alu_res;
    logic                   w_alu_carry;
    logic                   w_alu_ovf;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_addend;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic                   w_last;
    logic [WIDTH-1:0]       w_mul_res;
    logic                   w_mul_carry;

    // New work is taken only when idle and the output slot is free or draining.
    assign in_ready  = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_is_mul  = (op == OP_MUL) || (op == OP_MULHU);
    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign flags     = r_flags;
    assign busy      = (r_state == ST_MUL);

    // Single-cycle ALU result plus carry/overflow for the flag vector.
    always_comb begin
        w_alu_res   = {WIDTH{1'b0}};
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        w_sum       = {(WIDTH+1){1'b0}};
        case (op)
            OP_ADD: begin
                w_sum       = {1'b0, lhs} + {1'b0, rhs};
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
                w_alu_ovf   = (lhs[WIDTH-1] == rhs[WIDTH-1]) &&
                              (w_alu_res[WIDTH-1] != lhs[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res   = lhs - rhs;
                w_alu_carry = (lhs < rhs);
                w_alu_ovf   = (lhs[WIDTH-1] != rhs[WIDTH-1]) &&
                              (w_alu_res[WIDTH-1] != lhs[WIDTH-1]);
            end
            OP_SLL:  w_alu_res = lhs << rhs[SHW-1:0];
            OP_SRL:  w_alu_res = lhs >> rhs[SHW-1:0];
            OP_SRA:  w_alu_res = WIDTH'($signed(lhs) >>> rhs[SHW-1:0]);
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(lhs) < $signed(rhs))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (lhs < rhs)};
            OP_XOR:  w_alu_res = lhs ^ rhs;
            OP_OR:   w_alu_res = lhs | rhs;
            OP_AND:  w_alu_res = lhs & rhs;
            default: w_alu_res = {WIDTH{1'b0}};
        endcase
    end

    // One shift-add step: add multiplicand<<count when multiplier bit[count] is set.
    always_comb begin
        w_addend = {(2*WIDTH){1'b0}};
        if (r_mplier[r_count]) begin
            w_addend = {{WIDTH{1'b0}}, r_mcand} << r_count;
        end else begin
            w_addend = {(2*WIDTH){1'b0}};
        end
        w_acc_next  = r_acc + w_addend;
        w_last      = (r_count == SHW'(WIDTH-1));
        w_mul_res   = r_is_hi ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];
        w_mul_carry = !r_is_hi && (w_acc_next[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    end

    // FSM next state and result-register load selection.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_res_d      = r_res;
        w_flags_d    = r_flags;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_next = ST_MUL;
                end else if (w_accept) begin
                    w_load    = 1'b1;
                    w_res_d   = w_alu_res;
                    w_flags_d = calc_flags(w_alu_res, w_alu_carry, w_alu_ovf);
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                    w_load       = 1'b1;
                    w_res_d      = w_mul_res;
                    w_flags_d    = calc_flags(w_mul_res, w_mul_carry, 1'b0);
                end else begin
                    w_state_next = ST_MUL;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output slot: a new result wins; otherwise a completed transfer empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_res       <= {WIDTH{1'b0}};
            r_flags     <= 4'd0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_res       <= w_res_d;
            r_flags     <= w_flags_d;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Multiplier operand latch on accept, accumulate/count while iterating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_count  <= {SHW{1'b0}};
            r_is_hi  <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= lhs;
            r_mplier <= rhs;
            r_acc    <= {(2*WIDTH){1'b0}};
            r_count  <= {SHW{1'b0}};
            r_is_hi  <= (op == OP_MULHU);
        end else if (r_state == ST_MUL) begin
            r_acc    <= w_acc_next;
            r_count  <= r_count + SHW'(1);
        end else begin
            r_acc    <= r_acc;
            r_count  <= r_count;
        end
    end

endmodule
